// File: rtl/sram_model_pkg.sv
// ============================================================================
// sram_model_pkg : shared types and helpers for the cycle-based SRAM model
// Revision 1.0
// ============================================================================
`default_nettype none

package sram_model_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } sram_state_t;

  localparam int WAIT_W     = 4;
  localparam int MAX_DATA_W = 256;

  // Undriven bus floats high: the open-bus word is all ones over data_w bits.
  function automatic logic [MAX_DATA_W-1:0] open_bus_word(input int data_w);
    logic [MAX_DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) w[i] = 1'b1;
    end
    return w;
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_array.sv
// ============================================================================
// sram_array : word storage, one synchronous write port, one async read port
// Revision 1.0
// ============================================================================
`default_nettype none

module sram_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32768,
  parameter int IDX_W  = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sram_sync_model.sv
// ============================================================================
// sram_sync_model : clocked SRAM model with wait states, nwait and clear sweep
// Revision 1.0
// ============================================================================
`default_nettype none

module sram_sync_model
  import sram_model_pkg::*;
#(
  parameter int              ADDR_W         = 15,
  parameter int              DATA_W         = 8,
  parameter int              DEPTH          = 32768,
  parameter int              RD_WAIT        = 2,
  parameter int              WR_WAIT        = 1,
  parameter bit              CLEAR_ON_RESET = 1'b0,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ncs,
  input  logic              nwe,
  input  logic              noe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_en,
  output logic              nwait,
  output logic              busy
);

  localparam int                 IDX_W    = idx_width(DEPTH);
  localparam logic [ADDR_W:0]    DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0]  LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [WAIT_W-1:0]  RD_CNT   = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0]  WR_CNT   = WAIT_W'(WR_WAIT);
  localparam logic [DATA_W-1:0]  OPEN_BUS = DATA_W'(open_bus_word(DATA_W));
  localparam sram_state_t        RESET_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  sram_state_t       state;
  logic [WAIT_W-1:0] cnt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_din;
  logic              lat_wr;

  logic              in_range;
  logic              complete;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign in_range = ({1'b0, lat_addr} < DEPTH_L);
  // A deselect on the completion edge aborts, so completion requires ncs low.
  assign complete = (state == ST_ACCESS) && !ncs && (cnt == '0);

  // Gating with rst drops a write that would land on the reset edge.
  assign arr_we    = !rst && ((state == ST_CLEAR) || (complete && lat_wr && in_range));
  assign arr_waddr = (state == ST_CLEAR) ? clr_ptr[IDX_W-1:0] : lat_addr[IDX_W-1:0];
  assign arr_wdata = (state == ST_CLEAR) ? INIT_VALUE : lat_din;

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (lat_addr[IDX_W-1:0]),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET_ST;
      cnt      <= '0;
      clr_ptr  <= '0;
      dout     <= '0;
      lat_addr <= '0;
      lat_din  <= '0;
      lat_wr   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == LAST_PTR) begin
            state   <= ST_IDLE;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (!ncs) begin
            lat_addr <= addr;
            lat_din  <= din;
            lat_wr   <= !nwe;
            cnt      <= nwe ? RD_CNT : WR_CNT;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (ncs) begin
            state <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
          end else begin
            if (!lat_wr) dout <= in_range ? arr_rdata : OPEN_BUS;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ncs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dout_en = (state == ST_HOLD) && !lat_wr && !noe;
  assign nwait   = !(((state == ST_IDLE) && !ncs) || (state == ST_ACCESS) || (state == ST_CLEAR));
  assign busy    = (state != ST_IDLE) && (state != ST_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_sram_sync_model.sv
// ============================================================================
// tb_sram_sync_model : self-checking bench, main config plus clear-sweep config
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sram_sync_model;

  localparam int M_RD    = 2;
  localparam int M_WR    = 1;
  localparam int M_DEPTH = 16384;
  localparam int C_DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ncs, nwe, noe;
  logic [14:0] addr;
  logic [7:0]  din, dout;
  logic        dout_en, nwait, busy;

  logic        c_ncs, c_nwe, c_noe;
  logic [7:0]  c_addr, c_din, c_dout;
  logic        c_dout_en, c_nwait, c_busy;

  sram_sync_model #(
    .ADDR_W(15), .DATA_W(8), .DEPTH(M_DEPTH), .RD_WAIT(M_RD), .WR_WAIT(M_WR),
    .CLEAR_ON_RESET(1'b0), .INIT_VALUE(8'h00)
  ) u_main (
    .clk(clk), .rst(rst), .ncs(ncs), .nwe(nwe), .noe(noe), .addr(addr), .din(din),
    .dout(dout), .dout_en(dout_en), .nwait(nwait), .busy(busy)
  );

  sram_sync_model #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(C_DEPTH), .RD_WAIT(0), .WR_WAIT(0),
    .CLEAR_ON_RESET(1'b1), .INIT_VALUE(8'hEE)
  ) u_clr (
    .clk(clk), .rst(rst), .ncs(c_ncs), .nwe(c_nwe), .noe(c_noe), .addr(c_addr), .din(c_din),
    .dout(c_dout), .dout_en(c_dout_en), .nwait(c_nwait), .busy(c_busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word contents by address, plus the word dout should hold.
  logic [7:0] ref_mem [int];
  logic [7:0] last_rd;

  typedef struct {
    bit          wr;
    logic [14:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [14:0] a);
    if (int'(a) >= M_DEPTH) return 8'hFF;
    return ref_mem[int'(a)];
  endfunction

  // One full transaction on the main instance, held for 'hold' extra cycles.
  task automatic m_access(input bit wr, input logic [14:0] a, input logic [7:0] d,
                          input int hold, input logic [7:0] exp);
    int lowcnt;
    int w;
    w = wr ? M_WR : M_RD;
    @(negedge clk);
    ncs = 1'b0; nwe = !wr; addr = a; din = d; noe = 1'b1;
    #1 chk("nwait_in_request_cycle", nwait, 0);
    @(posedge clk);
    lowcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (nwait) break;
      lowcnt++;
    end
    chk("wait_cycles_after_accept", lowcnt, w + 1);
    chk("busy_in_hold", busy, 0);
    chk("dout_en_noe_high", dout_en, 0);
    noe = 1'b0;
    #1 chk("dout_en_noe_low", dout_en, !wr);
    if (wr) begin
      if (int'(a) < M_DEPTH) ref_mem[int'(a)] = d;
    end else begin
      last_rd = exp;
      chk("read_data", dout, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      noe = 1'($urandom_range(0, 1));
      #1 chk("hold_stable", {nwait, busy, dout_en, dout}, {1'b1, 1'b0, !wr && !noe, last_rd});
    end
    ncs = 1'b1; noe = 1'b1; nwe = 1'b1;
    @(negedge clk);
    chk("release_to_idle", {nwait, busy}, 2'b10);
  endtask

  // Start a transaction and deselect after k ACCESS cycles (k <= wait count).
  task automatic m_abort(input bit wr, input logic [14:0] a, input logic [7:0] d, input int k);
    @(negedge clk);
    ncs = 1'b0; nwe = !wr; addr = a; din = d; noe = 1'b0;
    @(posedge clk);
    repeat (k + 1) @(negedge clk);
    ncs = 1'b1; nwe = 1'b1;
    @(negedge clk);
    chk("abort_state", {nwait, busy, dout_en, dout}, {1'b1, 1'b0, 1'b0, last_rd});
    noe = 1'b1;
  endtask

  task automatic c_access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] q);
    @(negedge clk);
    c_ncs = 1'b0; c_nwe = !wr; c_addr = a; c_din = d;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c_nwait) break;
    end
    q = c_dout;
    c_ncs = 1'b1; c_nwe = 1'b1;
  endtask

  // Counts cycles with the clear instance stalling, starting at the current negedge.
  task automatic c_count_clear(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!(c_busy && !c_nwait)) break;
      n++;
      @(negedge clk);
    end
  endtask

  vec_t        tbl [9];
  logic [14:0] pool [16];

  initial begin
    int          n;
    int          nerr;
    logic [7:0]  q;
    bit          wr;
    logic [14:0] a;
    logic [7:0]  d;
    logic [7:0]  e;

    tbl = '{
      '{1'b1, 15'h1234, 8'hA5, 8'h00},
      '{1'b0, 15'h1234, 8'h00, 8'hA5},
      '{1'b0, 15'h7FFF, 8'h00, 8'hFF},
      '{1'b1, 15'h0000, 8'h00, 8'h00},
      '{1'b1, 15'h4000, 8'h55, 8'h00},
      '{1'b0, 15'h0000, 8'h00, 8'h00},
      '{1'b0, 15'h4000, 8'h00, 8'hFF},
      '{1'b1, 15'h3FFF, 8'h77, 8'h00},
      '{1'b0, 15'h3FFF, 8'h00, 8'h77}
    };

    rst = 1'b1;
    ncs = 1'b1; nwe = 1'b1; noe = 1'b0; addr = '0; din = '0;
    c_ncs = 1'b0; c_nwe = 1'b0; c_noe = 1'b1; c_addr = 8'd5; c_din = 8'h12;
    last_rd = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("main_reset_outputs", {dout, dout_en, nwait, busy}, {8'h00, 1'b0, 1'b1, 1'b0});
    chk("clear_reset_outputs", {c_dout, c_nwait, c_busy}, {8'h00, 1'b0, 1'b1});
    noe = 1'b1;

    // Clear sweep with a write request held pending: it must be ignored.
    rst = 1'b0;
    c_count_clear(n);
    c_ncs = 1'b1; c_nwe = 1'b1;
    chk("clear_sweep_cycles", n, C_DEPTH);
    nerr = 0;
    for (int i = 0; i < C_DEPTH; i++) begin
      c_access(1'b0, 8'(i), 8'h00, q);
      if (q !== 8'hEE) nerr++;
    end
    chk("clear_all_words_init", nerr, 0);
    c_access(1'b0, 8'd64, 8'h00, q);
    chk("clear_open_bus_64", q, 8'hFF);
    c_access(1'b0, 8'd255, 8'h00, q);
    chk("clear_open_bus_255", q, 8'hFF);

    // Reset at clr_ptr == 20 must restart a full-length sweep.
    c_access(1'b1, 8'd30, 8'h02, q);
    c_access(1'b1, 8'd0, 8'h01, q);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c_count_clear(n);
    chk("clear_restart_cycles", n, C_DEPTH);
    c_access(1'b0, 8'd30, 8'h00, q);
    chk("clear_restart_addr30", q, 8'hEE);
    c_access(1'b0, 8'd0, 8'h00, q);
    chk("clear_restart_addr0", q, 8'hEE);
    last_rd = 8'h00;

    for (int i = 0; i < 9; i++) m_access(tbl[i].wr, tbl[i].a, tbl[i].d, 1, tbl[i].exp);

    // One read with ncs held low for 10 cycles: single access, stable data.
    m_access(1'b0, 15'h1234, 8'h00, 10, 8'hA5);

    // Write aborted in ACCESS, then read aborted on its completion edge.
    m_access(1'b1, 15'h0010, 8'h11, 0, 8'h00);
    m_access(1'b0, 15'h0010, 8'h00, 0, 8'h11);
    m_abort(1'b1, 15'h0010, 8'h3C, 0);
    m_abort(1'b0, 15'h1234, 8'h00, M_RD);
    m_access(1'b0, 15'h0010, 8'h00, 0, 8'h11);

    // Reset while a write is in ACCESS drops the write.
    m_access(1'b1, 15'h0020, 8'h22, 0, 8'h00);
    @(negedge clk);
    ncs = 1'b0; nwe = 1'b0; addr = 15'h0020; din = 8'h99;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ncs = 1'b1; nwe = 1'b1;
    #1 chk("reset_mid_access", {dout, nwait, busy}, {8'h00, 1'b1, 1'b0});
    last_rd = 8'h00;
    m_access(1'b0, 15'h0020, 8'h00, 0, 8'h22);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 16; i++) begin
      pool[i] = (i < 8) ? 15'(i) : 15'(16'h3FF8 + i - 8);
      m_access(1'b1, pool[i], 8'($urandom_range(0, 255)), 0, 8'h00);
    end
    for (int i = 0; i < 60; i++) begin
      wr = bit'($urandom_range(0, 1));
      a  = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 4) == 0) a = a | 15'h4000;
      d  = 8'($urandom_range(0, 255));
      e  = model_read(a);
      if ($urandom_range(0, 5) == 0) m_abort(wr, a, d, $urandom_range(0, wr ? M_WR : M_RD));
      else m_access(wr, a, d, $urandom_range(0, 3), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation timeout");
  end

endmodule

`default_nettype wire
